// File: rtl/quad_enc_speed.sv
// quad_enc_speed: wheel encoder front end.
// Synchronises and glitch-filters the raw SA/SB Hall channels and decodes
// them in X4 quadrature. Outputs signed position, direction and a per-window
// signed rotation count used as speed feedback.
// Optional build macro: QUAD_ENC_ERR_CNT_EN enables the saturating
// illegal-transition counter on err_cnt. Without it, err_cnt is tied to zero.
module quad_enc_speed #(
  parameter int unsigned CLK_FREQ  = 200_000_000,
  parameter int unsigned SAMPLE_HZ = 100,
  parameter int unsigned FILT_LEN  = 8
) (
  input  logic               clk200M,
  input  logic               rstn,
  input  logic               sa,
  input  logic               sb,
  input  logic               clr_pos,
  output logic signed [31:0] pos,
  output logic               dir,
  output logic signed [31:0] rot_v,
  output logic               rot_v_valid,
  output logic [15:0]        err_cnt
);

  localparam int unsigned       WIN       = CLK_FREQ / SAMPLE_HZ;
  localparam int unsigned       WCNT_W    = $clog2(WIN);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN - 1);
  localparam logic [7:0]        FILT_LAST = 8'(FILT_LEN - 1);

  // Channel bit 1 is A, bit 0 is B throughout, so {fa,fb} == r_filt.
  logic [1:0]         w_raw;
  logic [1:0][2:0]    r_sync;
  logic [1:0][7:0]    r_fcnt;
  logic [1:0]         r_filt;
  logic [1:0]         r_prev;

  logic [1:0]         w_diff;
  logic               w_fwd;
  logic               w_rev;
  logic signed [31:0] w_step;
  logic signed [31:0] w_acc_next;

  logic signed [31:0] r_pos;
  logic               r_dir;
  logic [WCNT_W-1:0]  r_wcnt;
  logic signed [31:0] r_acc;
  logic signed [31:0] r_rot_v;
  logic               r_rot_v_valid;

  // Map a channel pair onto its position in the forward cycle 00,10,11,01.
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    logic [1:0] ph;
    case (ab)
      2'b00:   ph = 2'd0;
      2'b10:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

  assign w_raw = {sa, sb};

  // Three-flop synchroniser and stability filter for each channel.
  always_ff @(posedge clk200M) begin
    if (!rstn) begin
      r_sync <= '0;
      r_fcnt <= '0;
      r_filt <= '0;
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        r_sync[c] <= {r_sync[c][1:0], w_raw[c]};
        if (r_sync[c][2] == r_filt[c]) begin
          r_fcnt[c] <= '0;
        end else if (r_fcnt[c] == FILT_LAST) begin
          r_filt[c] <= r_sync[c][2];
          r_fcnt[c] <= '0;
        end else begin
          r_fcnt[c] <= r_fcnt[c] + 8'd1;
        end
      end
    end
  end

  // Previous filtered state, refreshed every cycle including illegal jumps.
  always_ff @(posedge clk200M) begin
    if (!rstn) begin
      r_prev <= '0;
    end else begin
      r_prev <= r_filt;
    end
  end

  // Phase distance: +1 forward, -1 (3) reverse, 2 means both bits flipped.
  always_comb begin
    w_diff     = phase_of(r_filt) - phase_of(r_prev);
    w_fwd      = (w_diff == 2'd1);
    w_rev      = (w_diff == 2'd3);
    w_step     = '0;
    if (w_fwd) begin
      w_step = 32'sd1;
    end else if (w_rev) begin
      w_step = -32'sd1;
    end
    w_acc_next = r_acc + w_step;
  end

  // Absolute position; a clear wins over a step in the same cycle.
  always_ff @(posedge clk200M) begin
    if (!rstn) begin
      r_pos <= '0;
    end else if (clr_pos) begin
      r_pos <= '0;
    end else begin
      r_pos <= r_pos + w_step;
    end
  end

  // Direction of the most recent legal step.
  always_ff @(posedge clk200M) begin
    if (!rstn) begin
      r_dir <= 1'b0;
    end else if (w_fwd) begin
      r_dir <= 1'b1;
    end else if (w_rev) begin
      r_dir <= 1'b0;
    end
  end

  // Sampling window: accumulate steps, publish and restart on the last cycle.
  always_ff @(posedge clk200M) begin
    if (!rstn) begin
      r_wcnt        <= '0;
      r_acc         <= '0;
      r_rot_v       <= '0;
      r_rot_v_valid <= 1'b0;
    end else if (r_wcnt == WCNT_LAST) begin
      r_wcnt        <= '0;
      r_acc         <= '0;
      r_rot_v       <= w_acc_next;
      r_rot_v_valid <= 1'b1;
    end else begin
      r_wcnt        <= r_wcnt + 1'b1;
      r_acc         <= w_acc_next;
      r_rot_v_valid <= 1'b0;
    end
  end

  assign pos         = r_pos;
  assign dir         = r_dir;
  assign rot_v       = r_rot_v;
  assign rot_v_valid = r_rot_v_valid;

`ifdef QUAD_ENC_ERR_CNT_EN
  logic        w_illegal;
  logic [15:0] r_err_cnt;

  assign w_illegal = (w_diff == 2'd2);

  // Saturating count of transitions where both channels moved together.
  always_ff @(posedge clk200M) begin
    if (!rstn) begin
      r_err_cnt <= '0;
    end else if (w_illegal && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_quad_enc_speed.sv
// Self-checking bench for quad_enc_speed. Clean encoder edges are logged as
// timed events (step appears on pos a fixed latency after being driven);
// position, direction and window sums are computed from that event log.
module tb_quad_enc_speed;

  localparam int unsigned CLK_FREQ  = 200_000_000;
  localparam int unsigned SAMPLE_HZ = 100_000;
  localparam int unsigned FILT_LEN  = 8;
  localparam int unsigned WIN       = CLK_FREQ / SAMPLE_HZ;
  localparam int unsigned LAT       = 3 + FILT_LEN + 1;

`ifdef QUAD_ENC_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic               clk200M = 1'b0;
  logic               rstn    = 1'b0;
  logic               sa      = 1'b0;
  logic               sb      = 1'b0;
  logic               clr_pos = 1'b0;
  logic signed [31:0] pos;
  logic               dir;
  logic signed [31:0] rot_v;
  logic               rot_v_valid;
  logic [15:0]        err_cnt;

  quad_enc_speed #(
    .CLK_FREQ (CLK_FREQ),
    .SAMPLE_HZ(SAMPLE_HZ),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .clk200M    (clk200M),
    .rstn       (rstn),
    .sa         (sa),
    .sb         (sb),
    .clr_pos    (clr_pos),
    .pos        (pos),
    .dir        (dir),
    .rot_v      (rot_v),
    .rot_v_valid(rot_v_valid),
    .err_cnt    (err_cnt)
  );

  always #5 clk200M = ~clk200M;

  int unsigned cyc = 0;
  always @(posedge clk200M) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    int          delta;
  } ev_t;

  ev_t         ev_q[$];
  int unsigned rst_edge = 0;
  int unsigned pos_base = 0;
  int          exp_err  = 0;
  int          checks   = 0;
  int          errors   = 0;
  bit          mon_en   = 1'b0;
  int unsigned ph       = 0;
  logic [1:0]  seq [4]  = '{2'b00, 2'b10, 2'b11, 2'b01};

  function automatic int model_pos(input int unsigned t);
    int s;
    s = 0;
    foreach (ev_q[i]) if (ev_q[i].at > pos_base && ev_q[i].at <= t) s += ev_q[i].delta;
    return s;
  endfunction

  function automatic logic model_dir(input int unsigned t);
    logic d;
    d = 1'b0;
    foreach (ev_q[i]) if (ev_q[i].at <= t) d = (ev_q[i].delta > 0);
    return d;
  endfunction

  function automatic int model_win(input int unsigned x);
    int s;
    s = 0;
    foreach (ev_q[i]) if (ev_q[i].at + WIN > x && ev_q[i].at <= x) s += ev_q[i].delta;
    return s;
  endfunction

  function automatic logic [15:0] model_err();
    return ERR_EN ? 16'(exp_err) : 16'd0;
  endfunction

  task automatic drive_step(input int d);
    ph = (d > 0) ? (ph + 1) % 4 : (ph + 3) % 4;
    {sa, sb} = seq[ph];
    ev_q.push_back('{at: cyc + LAT, delta: d});
  endtask

  task automatic pulse_clr();
    clr_pos = 1'b1;
    @(negedge clk200M);
    pos_base = cyc;
    clr_pos  = 1'b0;
  endtask

  task automatic do_reset(input int unsigned ncyc);
    rstn = 1'b0;
    repeat (ncyc) @(negedge clk200M);
    rstn     = 1'b1;
    rst_edge = cyc;
    pos_base = cyc;
    exp_err  = 0;
    ev_q.delete();
  endtask

  task automatic go_phase0();
    while (ph != 0) begin
      drive_step(1);
      repeat (30) @(negedge clk200M);
    end
  endtask

  // Every strobe must land on a window boundary and carry that window's sum.
  always @(negedge clk200M) begin
    bit exp_v;
    #1;
    if (mon_en && rstn) begin
      exp_v = (cyc > rst_edge) && (((cyc - rst_edge) % WIN) == 0);
      if (exp_v || rot_v_valid) begin
        checks++;
        if (rot_v_valid !== exp_v) begin
          errors++;
          $display("FAIL strobe_timing cyc=%0d: rot_v_valid=%b required %b", cyc, rot_v_valid, exp_v);
        end
        if (exp_v) begin
          checks++;
          if (rot_v !== model_win(cyc)) begin
            errors++;
            $display("FAIL strobe_value cyc=%0d: rot_v=%0d required %0d", cyc, rot_v, model_win(cyc));
          end
        end
      end
    end
  end

  task automatic test_reset();
    do_reset(4);
    mon_en = 1'b1;
    checks += 5;
    if (pos !== 32'sd0)        begin errors++; $display("FAIL reset_pos: pos=%0d required 0", pos); end
    if (dir !== 1'b0)          begin errors++; $display("FAIL reset_dir: dir=%b required 0", dir); end
    if (rot_v !== 32'sd0)      begin errors++; $display("FAIL reset_rot_v: rot_v=%0d required 0", rot_v); end
    if (rot_v_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: rot_v_valid=%b required 0", rot_v_valid); end
    if (err_cnt !== 16'd0)     begin errors++; $display("FAIL reset_err: err_cnt=%0d required 0", err_cnt); end
  endtask

  task automatic test_forward();
    int          p;
    int unsigned first_at;
    int          full_seen;
    p         = model_pos(cyc);
    first_at  = cyc + LAT;
    full_seen = 0;
    for (int k = 0; k < 60; k++) begin
      drive_step(1);
      for (int unsigned j = 1; j <= 100; j++) begin
        @(negedge clk200M);
        if (j == LAT - 1) begin
          checks++;
          if (pos !== p) begin errors++; $display("FAIL fwd_pos_before: pos=%0d required %0d", pos, p); end
        end
        if (j == LAT) begin
          checks += 2;
          if (pos !== p + 1) begin errors++; $display("FAIL fwd_pos_step: pos=%0d required %0d", pos, p + 1); end
          if (dir !== 1'b1)  begin errors++; $display("FAIL fwd_dir: dir=%b required 1", dir); end
        end
        if (rot_v_valid && (cyc + 1 >= first_at + WIN)) begin
          full_seen++;
          checks++;
          if (rot_v !== 32'sd20) begin errors++; $display("FAIL fwd_rot_v: rot_v=%0d required 20", rot_v); end
        end
      end
      p++;
    end
    checks++;
    if (full_seen < 1) begin errors++; $display("FAIL fwd_full_windows: seen=%0d required >=1", full_seen); end
  endtask

  task automatic test_reverse();
    go_phase0();
    pulse_clr();
    repeat (20) @(negedge clk200M);
    for (int k = 0; k < 12; k++) begin
      drive_step(-1);
      repeat (100) @(negedge clk200M);
      checks++;
      if (pos !== -(k + 1)) begin errors++; $display("FAIL rev_pos: pos=%0d required %0d", pos, -(k + 1)); end
    end
    checks += 2;
    if (dir !== 1'b0)      begin errors++; $display("FAIL rev_dir: dir=%b required 0", dir); end
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL rev_err: err_cnt=%0d required 0", err_cnt); end
  endtask

  task automatic test_glitch();
    int          p;
    int unsigned len;
    go_phase0();
    repeat (20) @(negedge clk200M);
    p = model_pos(cyc);
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, FILT_LEN - 1);
      if (t % 2 == 0) sa = ~sa; else sb = ~sb;
      repeat (len) @(negedge clk200M);
      {sa, sb} = seq[ph];
      repeat (25) @(negedge clk200M);
      checks += 2;
      if (pos !== p)               begin errors++; $display("FAIL glitch_pos len=%0d: pos=%0d required %0d", len, pos, p); end
      if (err_cnt !== model_err()) begin errors++; $display("FAIL glitch_err: err_cnt=%0d required %0d", err_cnt, model_err()); end
    end
    drive_step(1);
    for (int unsigned j = 1; j <= 45; j++) begin
      @(negedge clk200M);
      if (j == LAT - 1 || j == LAT || j == 20 + LAT - 1 || j == 20 + LAT) begin
        checks++;
        if (pos !== model_pos(cyc)) begin errors++; $display("FAIL pulse_pos j=%0d: pos=%0d required %0d", j, pos, model_pos(cyc)); end
      end
      if (j == 20) drive_step(-1);
    end
    checks++;
    if (pos !== p) begin errors++; $display("FAIL pulse_return: pos=%0d required %0d", pos, p); end
  endtask

  task automatic test_illegal();
    int   p;
    logic d;
    go_phase0();
    repeat (20) @(negedge clk200M);
    p = model_pos(cyc);
    d = model_dir(cyc);
    ph = 2;
    {sa, sb} = seq[ph];
    exp_err++;
    repeat (LAT + 5) @(negedge clk200M);
    checks += 3;
    if (pos !== p)               begin errors++; $display("FAIL illegal_pos: pos=%0d required %0d", pos, p); end
    if (dir !== d)               begin errors++; $display("FAIL illegal_dir: dir=%b required %b", dir, d); end
    if (err_cnt !== model_err()) begin errors++; $display("FAIL illegal_err: err_cnt=%0d required %0d", err_cnt, model_err()); end
  endtask

  task automatic test_clear();
    pulse_clr();
    for (int k = 0; k < 7; k++) begin
      drive_step(1);
      repeat (30) @(negedge clk200M);
    end
    checks++;
    if (pos !== 32'sd7) begin errors++; $display("FAIL clr_pre_pos: pos=%0d required 7", pos); end
    drive_step(1);
    repeat (LAT - 1) @(negedge clk200M);
    clr_pos = 1'b1;
    @(negedge clk200M);
    pos_base = cyc;
    clr_pos  = 1'b0;
    checks += 2;
    if (pos !== 32'sd0) begin errors++; $display("FAIL clr_pos_zero: pos=%0d required 0", pos); end
    if (dir !== 1'b1)   begin errors++; $display("FAIL clr_dir: dir=%b required 1", dir); end
    for (int unsigned i = 0; i < WIN + 2 && !rot_v_valid; i++) @(negedge clk200M);
    checks++;
    if (!rot_v_valid || rot_v !== model_win(cyc)) begin
      errors++;
      $display("FAIL clr_window: valid=%b rot_v=%0d required %0d", rot_v_valid, rot_v, model_win(cyc));
    end
  endtask

  task automatic test_midreset();
    go_phase0();
    drive_step(1);
    repeat (30) @(negedge clk200M);
    drive_step(1);
    repeat (30) @(negedge clk200M);
    pulse_clr();
    for (int k = 0; k < 10; k++) begin
      drive_step(1);
      repeat (30) @(negedge clk200M);
    end
    checks++;
    if (pos !== 32'sd10) begin errors++; $display("FAIL midrst_pre_pos: pos=%0d required 10", pos); end
    for (int unsigned i = 0; i < WIN && ((cyc - rst_edge) % WIN) != 1500; i++) @(negedge clk200M);
    do_reset(1);
    checks += 5;
    if (pos !== 32'sd0)       begin errors++; $display("FAIL midrst_pos: pos=%0d required 0", pos); end
    if (dir !== 1'b0)         begin errors++; $display("FAIL midrst_dir: dir=%b required 0", dir); end
    if (rot_v !== 32'sd0)     begin errors++; $display("FAIL midrst_rot_v: rot_v=%0d required 0", rot_v); end
    if (rot_v_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: rot_v_valid=%b required 0", rot_v_valid); end
    if (err_cnt !== 16'd0)    begin errors++; $display("FAIL midrst_err: err_cnt=%0d required 0", err_cnt); end
    for (int k = 0; k < 5; k++) begin
      drive_step(1);
      repeat (100) @(negedge clk200M);
    end
    for (int unsigned i = 0; i < WIN + 10 && !rot_v_valid; i++) @(negedge clk200M);
    checks += 3;
    if (!rot_v_valid || (cyc - rst_edge) != WIN) begin
      errors++;
      $display("FAIL midrst_strobe_time: valid=%b at %0d cycles after release required %0d", rot_v_valid, cyc - rst_edge, WIN);
    end
    if (rot_v !== 32'sd5) begin errors++; $display("FAIL midrst_rot_v: rot_v=%0d required 5", rot_v); end
    if (pos !== 32'sd5)   begin errors++; $display("FAIL midrst_post_pos: pos=%0d required 5", pos); end
  endtask

  task automatic test_random();
    int unsigned r;
    int unsigned gap;
    int unsigned len;
    for (int n = 0; n < 150; n++) begin
      r   = $urandom_range(0, 99);
      gap = $urandom_range(LAT, 50);
      if (r < 65) begin
        drive_step((r < 33) ? 1 : -1);
      end else if (r < 83) begin
        len = $urandom_range(1, FILT_LEN - 1);
        if (r[0]) sa = ~sa; else sb = ~sb;
        repeat (len) @(negedge clk200M);
        {sa, sb} = seq[ph];
      end else if (r < 93) begin
        ph = (ph + 2) % 4;
        {sa, sb} = seq[ph];
        exp_err++;
      end else begin
        pulse_clr();
      end
      repeat (gap) @(negedge clk200M);
      checks += 2;
      if (pos !== model_pos(cyc)) begin errors++; $display("FAIL rand_pos op=%0d: pos=%0d required %0d", n, pos, model_pos(cyc)); end
      if (dir !== model_dir(cyc)) begin errors++; $display("FAIL rand_dir op=%0d: dir=%b required %b", n, dir, model_dir(cyc)); end
    end
    checks++;
    if (err_cnt !== model_err()) begin errors++; $display("FAIL rand_err: err_cnt=%0d required %0d", err_cnt, model_err()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_clear();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_enc_speed.md
Name: quad_enc_speed

Overview:
- Upstream stage of the wheel motor controller. Takes the raw Hall-encoder channels SA and SB from a Pmod pin pair.
- Synchronises and glitch-filters both channels, then decodes them in X4 quadrature.
- Outputs a signed absolute position, a direction flag, and a per-window signed rotation count, which is the speed feedback for the P-gain loop.
- One instance per wheel, both clocked on clk200M.

Parameters:
- CLK_FREQ, 200_000_000, clock frequency in Hz.
- SAMPLE_HZ, 100, speed sampling rate in Hz. Window length WIN = CLK_FREQ/SAMPLE_HZ cycles; WIN must be at least 2.
- FILT_LEN, 8, consecutive stable cycles required before a filtered channel changes. Must be at least 1 and at most 255.

Ports:
- clk200M  in  1  clock.
- rstn  in  1  reset: synchronous, active-low; clock clk200M.
- sa  in  1  raw encoder channel A, asynchronous.
- sb  in  1  raw encoder channel B, asynchronous.
- clr_pos  in  1  synchronous clear of pos.
- pos  out  32  signed position, in quadrature counts.
- dir  out  1  direction of the last legal step; 1 = forward.
- rot_v  out  32  signed count accumulated over the last completed window.
- rot_v_valid  out  1  single-cycle strobe; high in the cycle rot_v updates.
- err_cnt  out  16  illegal-transition count (see Optional Feature).

Behaviour:
- Reset (rstn=0 sampled at a clk200M edge):
  - All sync flops, filtered channels, filter counters, previous state, window counter and accumulator are cleared.
  - Outputs: pos=0, dir=0, rot_v=0, rot_v_valid=0, err_cnt=0.
  - Reset mid-operation discards the partial window and restarts the window counter at 0.
- Synchroniser: 3 flops per channel, reset value 0.
- Filter, per channel:
  - An 8-bit counter increments while the synced input differs from the filtered value.
  - When the count reaches FILT_LEN-1 and the inputs still differ, the filtered value takes the input and the counter clears.
  - Any cycle where input equals the filtered value clears the counter.
  - A clean input edge reaches the filtered value 3+FILT_LEN cycles after it is applied.
- Decode:
  - prev = registered {fa,fb}, compared with the current {fa,fb} every cycle.
  - Forward sequence 00→10→11→01→00 gives step=+1; the reverse sequence gives step=−1; no change gives step=0.
  - Both bits changing in the same cycle is illegal: step=0, err pulse asserted.
  - prev updates every cycle, including on illegal transitions.
- pos:
  - pos <= pos+step, two's-complement wrap (0x7FFFFFFF +1 → 0x80000000).
  - clr_pos has priority: pos <= 0 and any step in that cycle is dropped from pos. The step still counts toward the window.
  - Output is registered: a step appears on pos 1 cycle after the filtered change.
- dir: set to 1 on step=+1, to 0 on step=−1, held otherwise.
- Window:
  - wcnt counts 0..WIN−1 and wraps; it starts at 0 in the first cycle after reset release.
  - acc += step every cycle.
  - When wcnt=WIN−1: rot_v <= acc+step, acc <= 0, rot_v_valid <= 1 for the next cycle only.
  - The first strobe is visible WIN cycles after reset release, then every WIN cycles.
  - acc is 32-bit signed and cannot overflow within a window of at most 2^31 cycles.
- clr_pos does not affect acc, rot_v or the window timing.

Optional Feature:
- Macro QUAD_ENC_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on each illegal transition and saturates at 16'hFFFF; it clears only on reset.
- Undefined: err_cnt is tied to 16'h0000, no counter logic is built, and pos/dir/rot_v behaviour is identical.

Test Plan:
All tests use CLK_FREQ=200_000_000, SAMPLE_HZ=100_000 (WIN=2000) and FILT_LEN=8.
1. Forward quadrature, one edge every 100 cycles, sustained over 3 windows → rot_v=20 on every strobe after the first full window, dir=1, pos increases by exactly 1 per edge.
2. Reverse sequence 00→01→11→10→00 repeated 3 times (12 edges, 100-cycle spacing) → pos=−12, dir=0, err_cnt=0.
3. From a stable state, a 5-cycle high pulse on sa → pos and err_cnt unchanged. A 20-cycle high pulse on sa → pos goes +1 then back by −1, with each step seen on pos 3+8+1=12 cycles after its edge.
4. sa and sb driven 00→11 in the same cycle → pos unchanged. err_cnt=1 with QUAD_ENC_ERR_CNT_EN defined, 0 without it.
5. pos=7, then clr_pos asserted in the same cycle a +1 step is decoded → pos=0 next cycle, and the window acc still includes the +1.
6. rstn held low 1 cycle at wcnt≈1500 with pos=10 → all outputs 0 next cycle; the next rot_v_valid occurs exactly 2000 cycles after release, with rot_v covering only post-reset edges.
